// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one combinational fp32 multiplier
// among NUM_REQ requesters. Operands are registered into the multiplier, the
// product runs through PIPE_STG result stages, and it lands in a
// credit-protected result FIFO tagged with the requester index.
//
// Build option: define MUL_SHARE_ARB_STALL_CNT_EN to build the credit-stall
// counter on stall_cnt. Without it, stall_cnt is tied to zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the request side, req_ready is a combinational function of
// req_valid, so requesters must not derive req_valid from req_ready. On the
// response side, rsp_valid depends only on FIFO state, never on rsp_ready.
module mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 32,
   parameter int PIPE_STG   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   input  logic [NUM_REQ*2-1:0]         req_rnd,
   output logic [DATA_W-1:0]            mul_a,
   output logic [DATA_W-1:0]            mul_b,
   output logic [1:0]                   mul_rnd,
   input  logic [DATA_W-1:0]            mul_res,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_data,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [31:0]                  stall_cnt
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Index p+k, wrapped into 0..NUM_REQ-1 (NUM_REQ need not be a power of two).
   function automatic logic [ID_W-1:0] ptr_add(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Arbitration state and grant
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    w_cand;
   logic [ID_W-1:0]    w_gnt_idx;
   logic               w_gnt_any;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_credit_ok;
   logic               w_issue;

   // Operand stage (stage 0) and result stages 1..PIPE_STG
   logic [DATA_W-1:0]  r_mul_a;
   logic [DATA_W-1:0]  r_mul_b;
   logic [1:0]         r_mul_rnd;
   logic               r_s0_vld;
   logic [ID_W-1:0]    r_s0_id;
   logic               r_st_vld  [1:PIPE_STG];
   logic [ID_W-1:0]    r_st_id   [1:PIPE_STG];
   logic [DATA_W-1:0]  r_st_data [1:PIPE_STG];

   // Credits and result FIFO
   logic [CNT_W-1:0]   r_credits;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
   logic [ID_W-1:0]    r_fifo_id   [FIFO_DEPTH];
   logic               w_push;
   logic               w_pop;

   // Round-robin search upward from r_rr_ptr; first valid requester wins.
   always_comb begin
      w_grant   = '0;
      w_gnt_idx = '0;
      w_gnt_any = 1'b0;
      w_cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = ptr_add(r_rr_ptr, k);
         if (!w_gnt_any && req_valid[w_cand]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
      if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
   end

   assign w_credit_ok = (r_credits != '0);
   assign req_ready   = w_grant & {NUM_REQ{w_credit_ok & ~rst}};
   assign w_issue     = w_gnt_any & w_credit_ok & ~rst;

   assign w_push    = r_st_vld[PIPE_STG];
   assign rsp_valid = (r_count != '0);
   assign w_pop     = rsp_valid & rsp_ready;

   // Issue: capture the winner's operands; operands hold when nothing issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_mul_rnd <= '0;
         r_s0_vld  <= 1'b0;
         r_s0_id   <= '0;
      end else begin
         r_s0_vld <= w_issue;
         if (w_issue) begin
            r_rr_ptr  <= ptr_add(w_gnt_idx, 1);
            r_mul_a   <= req_a[w_gnt_idx*DATA_W +: DATA_W];
            r_mul_b   <= req_b[w_gnt_idx*DATA_W +: DATA_W];
            r_mul_rnd <= req_rnd[w_gnt_idx*2 +: 2];
            r_s0_id   <= w_gnt_idx;
         end
      end
   end

   assign mul_a   = r_mul_a;
   assign mul_b   = r_mul_b;
   assign mul_rnd = r_mul_rnd;

   // Result pipeline: stage 1 samples the multiplier, later stages shift; never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 1; s <= PIPE_STG; s++) begin
            r_st_vld[s]  <= 1'b0;
            r_st_id[s]   <= '0;
            r_st_data[s] <= '0;
         end
      end else begin
         r_st_vld[1]  <= r_s0_vld;
         r_st_id[1]   <= r_s0_id;
         r_st_data[1] <= mul_res;
         for (int s = 2; s <= PIPE_STG; s++) begin
            r_st_vld[s]  <= r_st_vld[s-1];
            r_st_id[s]   <= r_st_id[s-1];
            r_st_data[s] <= r_st_data[s-1];
         end
      end
   end

   // Credits track free FIFO slots minus results still in the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= CNT_W'(FIFO_DEPTH);
      end else begin
         case ({w_issue, w_pop})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   // FIFO pointers and occupancy; credits guarantee no write ever finds it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are only visible while the entry is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= r_st_data[PIPE_STG];
         r_fifo_id[r_wr_ptr]   <= r_st_id[PIPE_STG];
      end
   end

   assign rsp_data = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign rsp_id   = rsp_valid ? r_fifo_id[r_rd_ptr]   : '0;

`ifdef MUL_SHARE_ARB_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Count cycles where someone wants to issue but no credit is left; saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if ((|req_valid) && (r_credits == '0) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one combinational fp32 multiplier among `NUM_REQ` requesters. Each requester offers an operand pair and rounding mode on a valid/ready channel. The block issues one product per cycle into a registered pipeline around the external multiplier, then returns tagged results through a credit-protected result FIFO. It sits between the vector/scalar issue logic and the multiplier core.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: operand/result width; sign+expo+mant, fp32 layout.
- `PIPE_STG`, default 2: result register stages after the multiplier, >=1.
- `FIFO_DEPTH`, default 4: result FIFO entries, power of two, >=2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester operand valid.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit high.
- `req_a`, `req_b` in NUM_REQ*DATA_W: packed operands; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_rnd` in NUM_REQ*2: packed rounding mode, same encoding as the multiplier.
- `mul_a`, `mul_b` out DATA_W: registered operands to the multiplier.
- `mul_rnd` out 2: registered rounding mode to the multiplier.
- `mul_res` in DATA_W: combinational multiplier result for `mul_a`/`mul_b`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accept.
- `rsp_data` out DATA_W: product.
- `rsp_id` out $clog2(NUM_REQ): originating requester index.
- `stall_cnt` out 32: credit-stall counter; see Configuration.

## Operation
- **Grant:** combinational round-robin over `req_valid`, searching upward from pointer `rr_ptr` with wrap from NUM_REQ-1 to 0. `req_ready[g]` = grant[g] & (credits != 0) & !rst.
- **Issue:** occurs on a cycle with `req_valid[g]` & `req_ready[g]`.
  - `req_a`/`req_b`/`req_rnd` of g load into `mul_a`/`mul_b`/`mul_rnd`.
  - Issue valid bit and id g load into stage 0.
  - `rr_ptr` <- (g+1) mod NUM_REQ.
  - With no issue, `rr_ptr` holds and the operand registers hold their values; only the valid bit clears.
- **Pipeline:** stage 1 captures `mul_res` plus valid/id from stage 0. Stages 2..PIPE_STG shift. The valid last stage writes the FIFO. The pipeline never stalls.
- **Credits:**
  - Counter range 0..FIFO_DEPTH; reset value FIFO_DEPTH.
  - Decrements on issue; increments on `rsp_valid` & `rsp_ready`.
  - Issue and response in the same cycle leave it unchanged.
  - Because of this, the FIFO can never overflow, and an in-flight result is never dropped.
- **FIFO:**
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - `rsp_valid` = !empty.
  - `rsp_data`/`rsp_id` come from the head entry.
  - Simultaneous write and read on a full FIFO is legal. It cannot arise at credit limit with an extra write.
- **Ordering:** results leave in issue order. There is no reordering across requesters.
- **Reset:**
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `mul_a`=`mul_b`=0, `mul_rnd`=0.
  - All stage valids=0, `rr_ptr`=0, credits=FIFO_DEPTH, FIFO empty, `stall_cnt`=0.
  - Reset mid-operation discards all in-flight and buffered results; no response is produced for them.

## Timing
- Issue handshake at edge k → `mul_a`/`mul_b` valid after edge k.
- Stage 1 captures at edge k+1; last stage at edge k+PIPE_STG; FIFO write at edge k+PIPE_STG+1.
- `rsp_valid` is high from edge k+PIPE_STG+1, i.e. PIPE_STG+1 cycles after acceptance. The default is 3.
- Throughput: one issue per cycle while credits > 0.
- With `rsp_ready` held low, at most FIFO_DEPTH issues are accepted; then every `req_ready` is 0.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- `req_valid` may drop without a handshake; there is no sticky grant.

## Configuration
- `MUL_SHARE_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` increments once per cycle in which any `req_valid` is high and credits == 0.
  - It saturates at 32'hFFFF_FFFF and clears on `rst`.
- Undefined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Single issue:** requester 2 offers a=0x3F800000, b=0x40000000, rnd=0, with `rsp_ready`=1. Expect `rsp_valid` 3 cycles after acceptance with `rsp_data`=0x40000000, `rsp_id`=2, and credits back to 4.
- **Fairness:** all 4 requesters hold valid continuously with `rsp_ready`=1. Grants go 0,1,2,3,0,… one per cycle, and `rsp_id` follows the same sequence.
- **Backpressure:** `rsp_ready`=0 with requester 0 always valid. Exactly 4 accepts, then `req_ready`=0. With the macro on, `stall_cnt` increments every later cycle. Raising `rsp_ready` resumes issue, and no result is lost or duplicated.
- **Simultaneous events:** at credits=1, issue and response handshake occur in the same cycle. Credits stay 1 and the next cycle accepts again.
- **Pointer wrap:** only requester 3 is valid, then requesters 3 and 0 are valid. Requester 0 wins next because `rr_ptr` wrapped to 0.
- **Reset mid-flight:** assert `rst` for 1 cycle with 3 results in flight and 1 buffered. All outputs return to reset values, no `rsp_valid` appears afterwards, and credits=4.
